// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and segment lookup for the 7-segment scan driver
package seg7_pkg;

    localparam int BCD_W = 4;

    // Segment patterns, active-high, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal codes render as a dash so bad data is visible rather than garbled
    function automatic logic [6:0] seg7_lut(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to a-g segment decoder
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [6:0]       seg_o
);

    // Pure table lookup; blanking is handled by the caller
    always_comb begin
        seg_o = seg7_lut(digit_i);
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - frame-synchronous multiplexed 7-segment display driver
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic                        blank_lz,
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int DISP_W = BCD_W * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int PC_W   = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(CLK_DIV - 1);

    logic [PC_W-1:0]       pcnt_q, pcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DISP_W-1:0]     pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    logic                  advance;
    logic                  boundary;
    logic                  commit;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic [BCD_W-1:0]      sel_digit;
    logic [6:0]            dec_seg;
    logic                  blank_sel;

    // Prescaler, digit index and frame-synchronous pending/display handoff
    always_comb begin
        advance  = (pcnt_q == LAST_PC);
        boundary = advance && (idx_q == LAST_IDX);
        pcnt_d   = advance ? '0 : pcnt_q + 1'b1;
        if (advance) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
            idx_d = idx_q;
        end
        // The old pending value commits before a same-cycle load replaces it
        commit   = boundary && pend_v_q;
        disp_d   = commit ? pend_q : disp_q;
        pend_d   = load ? bcd_in : pend_q;
        pend_v_d = load | (pend_v_q & ~commit);
    end

    // Leading-zero map and digit select, both taken from the display value being entered
    always_comb begin
        lz_blank  = '0;
        zero_run  = 1'b1;
        sel_digit = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run & (disp_d[k*BCD_W +: BCD_W] == '0);
            lz_blank[k] = zero_run;
        end
        lz_blank[0] = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                sel_digit = disp_d[k*BCD_W +: BCD_W];
            end
        end
    end

    seg7_decode u_decode (
        .digit_i (sel_digit),
        .seg_o   (dec_seg)
    );

    // Output registers load only on an advance so an switches cleanly from one digit to the next
    always_comb begin
        blank_sel = blank_lz && lz_blank[idx_d];
        seg_d     = seg_q;
        an_d      = an_q;
        if (advance) begin
            seg_d = blank_sel ? SEG_BLANK : dec_seg;
            an_d  = blank_sel ? '0 : (NUM_DIGITS'(1) << idx_d);
        end
        fd_d = boundary;
    end

    // State registers with asynchronous clear; a reset drops any pending load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q   <= '0;
            idx_q    <= LAST_IDX;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            disp_q   <= '0;
            seg_q    <= '0;
            an_q     <= '0;
            fd_q     <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            disp_q   <= disp_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - randomized and directed checks of seg7_scan_mux against a timing model
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int CD = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks;
    int failures;

    seg7_scan_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: time-based view of the scan (edge count since release)
    logic [6:0]  seg_tab [16];
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fd;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pv;
    int          t_edges;

    initial begin
        seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
        seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
        seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
        seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
        seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000001;
    end

    initial begin
        int  slot;
        bit  adv;
        bit  bnd;
        bit  blanked;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t_edges = 0;
                m_disp  = '0;
                m_pend  = '0;
                m_pv    = 1'b0;
                exp_seg = '0;
                exp_an  = '0;
                exp_fd  = 1'b0;
            end else begin
                t_edges++;
                adv  = (t_edges % CD) == 0;
                slot = adv ? ((t_edges / CD) - 1) % ND : 0;
                bnd  = adv && (slot == 0);
                if (bnd && m_pv) begin
                    m_disp = m_pend;
                    m_pv   = 1'b0;
                end
                if (load) begin
                    m_pend = bcd_in;
                    m_pv   = 1'b1;
                end
                exp_fd = bnd;
                if (adv) begin
                    blanked = blank_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 0);
                    exp_seg = blanked ? 7'd0 : seg_tab[(m_disp >> (4 * slot)) & 16'hF];
                    exp_an  = blanked ? 4'd0 : 4'(1 << slot);
                end
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("seg", 32'(seg), 32'(exp_seg));
            check("an", 32'(an), 32'(exp_an));
            check("frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    task automatic do_load(input logic [15:0] v);
        load   = 1'b1;
        bcd_in = v;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("fd_wait", 32'(frame_done), 32'd1);
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
        check({tag, "_an"}, 32'(an), 32'(e_an));
        check({tag, "_seg"}, 32'(seg), 32'(e_seg));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk_slot("rst", 4'b0000, 7'b0000000);
        rst_n = 1'b1;

        // Idle after reset: dark for three cycles, digit 0 on the fourth
        repeat (3) @(negedge clk);
        check("pre_an", 32'(an), 32'd0);
        @(negedge clk);
        chk_slot("first", 4'b0001, 7'b1111110);
        check("first_fd", 32'(frame_done), 32'd1);
        @(negedge clk);
        check("fd_one", 32'(frame_done), 32'd0);

        // Mid-frame load stays invisible until the boundary
        do_load(16'h1234);
        repeat (2) @(negedge clk);
        chk_slot("old", 4'b0010, 7'b1111110);
        wait_fd(40);
        chk_slot("d0_4", 4'b0001, 7'b0110011);
        repeat (4) @(negedge clk);
        chk_slot("d1_3", 4'b0010, 7'b1111001);
        repeat (4) @(negedge clk);
        chk_slot("d2_2", 4'b0100, 7'b1101101);
        repeat (4) @(negedge clk);
        chk_slot("d3_1", 4'b1000, 7'b0110000);

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0070);
        wait_fd(40);
        chk_slot("lz_d0", 4'b0001, 7'b1111110);
        repeat (4) @(negedge clk);
        chk_slot("lz_d1", 4'b0010, 7'b1110000);
        repeat (4) @(negedge clk);
        chk_slot("lz_d2", 4'b0000, 7'b0000000);
        repeat (4) @(negedge clk);
        chk_slot("lz_d3", 4'b0000, 7'b0000000);
        do_load(16'h0000);
        wait_fd(40);
        chk_slot("z_d0", 4'b0001, 7'b1111110);
        repeat (4) @(negedge clk);
        chk_slot("z_d1", 4'b0000, 7'b0000000);

        // Dash counts as nonzero
        do_load(16'h0A00);
        wait_fd(40);
        chk_slot("a_d0", 4'b0001, 7'b1111110);
        repeat (4) @(negedge clk);
        chk_slot("a_d1", 4'b0010, 7'b1111110);
        repeat (4) @(negedge clk);
        chk_slot("a_d2", 4'b0100, 7'b0000001);
        repeat (4) @(negedge clk);
        chk_slot("a_d3", 4'b0000, 7'b0000000);

        // Last load wins; a load on the boundary edge waits a frame
        blank_lz = 1'b0;
        wait_fd(40);
        do_load(16'h1111);
        do_load(16'h2222);
        wait_fd(40);
        chk_slot("last_wins", 4'b0001, 7'b1101101);
        do_load(16'h5555);
        repeat (14) @(negedge clk);
        load   = 1'b1;
        bcd_in = 16'h6666;
        @(negedge clk);
        load = 1'b0;
        check("coinc_fd", 32'(frame_done), 32'd1);
        chk_slot("coinc_old", 4'b0001, 7'b1011011);
        repeat (15) @(negedge clk);
        chk_slot("coinc_hold", 4'b1000, 7'b1011011);
        @(negedge clk);
        check("coinc_fd2", 32'(frame_done), 32'd1);
        chk_slot("coinc_new", 4'b0001, 7'b1011111);

        // Asynchronous reset mid-frame discards display and pending
        do_load(16'h1234);
        wait_fd(40);
        do_load(16'h9876);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_slot("arst", 4'b0000, 7'b0000000);
        check("arst_fd", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rel_dark", 32'(an), 32'd0);
        @(negedge clk);
        chk_slot("rel_first", 4'b0001, 7'b1111110);
        wait_fd(40);
        chk_slot("rel_nopend", 4'b0001, 7'b1111110);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load   = ($urandom_range(0, 7) == 0);
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bcd_in[15:8] = 8'h00;
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 499) == 0) begin
                load = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_slot("rnd_arst", 4'b0000, 7'b0000000);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
